// File: rtl/dm_be_if.sv
// dm_be_if: MEM-stage data-memory bus between the pipeline (master) and dm_be (slave).
interface dm_be_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        busy;
    logic        misalign;
    logic        range_err;
    modport master (output addr, wdata, we, size, load_unsigned, pc,
                    input  rdata, busy, misalign, range_err);
    modport slave  (input  addr, wdata, we, size, load_unsigned, pc,
                    output rdata, busy, misalign, range_err);
endinterface

// File: rtl/dm_be.sv
// dm_be: byte-addressable data memory with sub-word loads/stores, alignment/range checks
// and a multi-cycle clear sweep after reset so the array can live in block RAM.
module dm_be #(
    parameter int ADDR_BITS = 12,
    parameter bit LOG_EN    = 1'b1
) (
    input logic     clk,
    input logic     reset,
    dm_be_if.slave  bus
);
    localparam int DEPTH = 1 << (ADDR_BITS - 2);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [31:0]          r_mem [DEPTH] = '{default: '0};
    logic [0:0]           r_state = IDLE;
    logic [ADDR_BITS-3:0] r_ptr = '0;

    logic [ADDR_BITS-3:0] w_idx;
    logic [31:0]          w_word;
    logic [31:0]          w_lane;
    logic [31:0]          w_merged;
    logic [31:0]          w_ext;
    logic [15:0]          w_half;
    logic [7:0]           w_byte;
    logic [3:0]           w_be;
    logic                 w_busy;
    logic                 w_mis;
    logic                 w_rng;
    logic                 w_commit;

    assign w_idx    = bus.addr[ADDR_BITS-1:2];
    assign w_word   = r_mem[w_idx];
    assign w_busy   = (r_state == CLEAR);
    assign w_mis    = (bus.size == 2'b00) ? 1'b0 :
                      (bus.size == 2'b01) ? bus.addr[0] : |bus.addr[1:0];
    assign w_rng    = |bus.addr[31:ADDR_BITS];
    assign w_commit = !w_busy && !reset && bus.we && !w_mis && !w_rng;

    // Store data is replicated across lanes so each enabled lane just picks its own slice.
    assign w_be   = (bus.size == 2'b00) ? 4'b0001 << bus.addr[1:0] :
                    (bus.size == 2'b01) ? (bus.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_lane = (bus.size == 2'b00) ? {4{bus.wdata[7:0]}} :
                    (bus.size == 2'b01) ? {2{bus.wdata[15:0]}} : bus.wdata;

    always_comb begin
        w_merged = w_word;
        for (int i = 0; i < 4; i++)
            if (w_be[i]) w_merged[8*i +: 8] = w_lane[8*i +: 8];
    end

    assign w_byte = w_word[{bus.addr[1:0], 3'b000} +: 8];
    assign w_half = w_word[{bus.addr[1], 4'b0000} +: 16];
    assign w_ext  = (bus.size == 2'b00) ? {{24{~bus.load_unsigned & w_byte[7]}}, w_byte} :
                    (bus.size == 2'b01) ? {{16{~bus.load_unsigned & w_half[15]}}, w_half} : w_word;

    assign bus.rdata     = (w_busy || w_mis || w_rng) ? 32'h0 : w_ext;
    assign bus.busy      = w_busy;
    assign bus.misalign  = w_mis;
    assign bus.range_err = w_rng;

    // The pointer width spans exactly DEPTH words, so it wraps back to 0 at the end of the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else if (r_state == CLEAR) begin
            r_mem[r_ptr] <= '0;
            r_ptr        <= r_ptr + 1'b1;
            if (&r_ptr) r_state <= IDLE;
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
            if (LOG_EN)
                $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, w_merged);
        end
    end
endmodule

// File: tb/tb_dm_be.sv
// tb_dm_be: directed bench for dm_be with a byte-level reference model checked every cycle,
// plus a second small instance (ADDR_BITS=8) for range and sweep-length checks.
module tb_dm_be;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic r2 = 1'b0;
    int n_chk = 0;
    int n_bad = 0;
    int n;

    dm_be_if b1();
    dm_be_if b2();

    dm_be #(.ADDR_BITS(12), .LOG_EN(1'b1)) u1 (.clk(clk), .reset(rst), .bus(b1));
    dm_be #(.ADDR_BITS(8),  .LOG_EN(1'b0)) u2 (.clk(clk), .reset(r2),  .bus(b2));

    always #5 clk = ~clk;

    logic [31:0] m_mem [1024] = '{default: '0};
    int m_left = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit m_mis(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd0) ? 1'b0 : (s == 2'd1) ? (a % 2 != 0) : (a % 4 != 0);
    endfunction

    function automatic bit m_rng(input logic [31:0] a);
        return a >= 32'd4096;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [1:0] s,
                                            input logic [31:0] a, input logic [31:0] d);
        int nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        logic [31:0] w = old;
        for (int k = 0; k < nb; k++) w[8*(a%4+k) +: 8] = d[8*k +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_rdata();
        logic [31:0] a = b1.addr;
        logic [31:0] w, v;
        if (m_left > 0 || m_mis(b1.size, a) || m_rng(a)) return 32'h0;
        w = m_mem[a/4];
        if (b1.size == 2'd0) begin
            v = (w >> (8*(a%4))) & 32'hFF;
            if (!b1.load_unsigned && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (b1.size == 2'd1) begin
            v = (w >> (16*((a/2)%2))) & 32'hFFFF;
            if (!b1.load_unsigned && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else v = w;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) m_left <= 1024;
        else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) for (int i = 0; i < 1024; i++) m_mem[i] <= '0;
        end else if (b1.we && !m_mis(b1.size, b1.addr) && !m_rng(b1.addr))
            m_mem[b1.addr/4] <= m_merge(m_mem[b1.addr/4], b1.size, b1.addr, b1.wdata);
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, b1.busy}, {31'd0, m_left > 0});
        chk("misalign", {31'd0, b1.misalign}, {31'd0, m_mis(b1.size, b1.addr)});
        chk("range_err", {31'd0, b1.range_err}, {31'd0, m_rng(b1.addr)});
        chk("rdata", b1.rdata, m_rdata());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic w, input logic [1:0] s, input logic lu,
                      input logic [31:0] a, input logic [31:0] d);
        b1.we = w; b1.size = s; b1.load_unsigned = lu; b1.addr = a; b1.wdata = d;
        b1.pc = b1.pc + 32'd4;
    endtask

    task automatic st(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        op(1'b1, s, 1'b0, a, d);
        step();
        b1.we = 1'b0;
    endtask

    task automatic ld(input logic [1:0] s, input logic lu, input logic [31:0] a,
                      input logic [31:0] exp, input string nm);
        op(1'b0, s, lu, a, 32'h0);
        #2;
        chk(nm, b1.rdata, exp);
        step();
    endtask

    task automatic count(output int cnt);
        cnt = 0;
        while (b1.busy && cnt < 3000) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        b1.pc = 32'h0040_0000;
        op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        b2.we = 1'b0; b2.size = 2'd2; b2.load_unsigned = 1'b0;
        b2.addr = 32'h0; b2.wdata = 32'h0; b2.pc = 32'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("busy_after_reset", {31'd0, b1.busy}, 32'd1);
        op(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
        count(n);
        b1.we = 1'b0;
        chk("sweep_len", 32'(n), 32'd1024);
        ld(2'd2, 1'b0, 32'h40, 32'h0, "store_during_busy");
        st(2'd2, 32'h10, 32'h11223344);
        st(2'd0, 32'h11, 32'hAA);
        st(2'd0, 32'h13, 32'hBB);
        ld(2'd2, 1'b0, 32'h10, 32'hBB22AA44, "byte_merge");
        st(2'd2, 32'h20, 32'h80FF7F01);
        ld(2'd0, 1'b0, 32'h22, 32'hFFFFFFFF, "lb");
        ld(2'd0, 1'b1, 32'h23, 32'h00000080, "lbu");
        ld(2'd1, 1'b0, 32'h22, 32'hFFFF80FF, "lh");
        ld(2'd1, 1'b1, 32'h20, 32'h00007F01, "lhu");
        st(2'd2, 32'h30, 32'h12345678);
        op(1'b1, 2'd1, 1'b0, 32'h31, 32'hBEEF);
        #2;
        chk("sh_misalign", {31'd0, b1.misalign}, 32'd1);
        chk("sh_mis_rdata", b1.rdata, 32'h0);
        step();
        op(1'b1, 2'd2, 1'b0, 32'h32, 32'hCAFEF00D);
        #2;
        chk("sw_misalign", {31'd0, b1.misalign}, 32'd1);
        step();
        b1.we = 1'b0;
        ld(2'd2, 1'b0, 32'h30, 32'h12345678, "misalign_dropped");
        op(1'b0, 2'd0, 1'b0, 32'h31, 32'h0);
        #2;
        chk("sb_no_misalign", {31'd0, b1.misalign}, 32'd0);
        step();
        op(1'b1, 2'd2, 1'b0, 32'h1000, 32'h55555555);
        #2;
        chk("range_err", {31'd0, b1.range_err}, 32'd1);
        step();
        b1.we = 1'b0;
        ld(2'd2, 1'b0, 32'h0, 32'h0, "range_dropped");
        op(1'b1, 2'd2, 1'b0, 32'h40, 32'h5);
        #2;
        chk("rdw_old", b1.rdata, 32'h0);
        step();
        b1.we = 1'b0;
        #2;
        chk("rdw_new", b1.rdata, 32'h5);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (500) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count(n);
        chk("restart_len", 32'(n), 32'd1024);
        ld(2'd2, 1'b0, 32'h10, 32'h0, "cleared_after_sweep");
        r2 = 1'b1;
        step();
        r2 = 1'b0;
        n = 0;
        while (b2.busy && n < 300) begin
            step();
            n++;
        end
        chk("small_sweep_len", 32'(n), 32'd64);
        b2.we = 1'b1; b2.size = 2'd2; b2.addr = 32'h100; b2.wdata = 32'h99;
        #2;
        chk("small_range_err", {31'd0, b2.range_err}, 32'd1);
        step();
        b2.addr = 32'hFC; b2.wdata = 32'h77;
        step();
        b2.we = 1'b0; b2.addr = 32'h0;
        #2;
        chk("small_range_dropped", b2.rdata, 32'h0);
        b2.addr = 32'hFC;
        #2;
        chk("small_top_word", b2.rdata, 32'h77);
        step();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/dm_be.md
# dm_be

Byte-addressable data memory for the MIPS32 pipeline's MEM stage. It replaces the word-only data memory with parametrised depth, byte and halfword stores, sign- and zero-extending loads, and alignment and range checking. Memory clear on reset is a multi-cycle sweep, so the array maps to block RAM; `busy` stalls the pipeline during the sweep. Every committed store prints the standard trace line used by the course checker.

## Interface
Parameters:
- `ADDR_BITS`, default 12: byte-address bits decoded; depth is DEPTH = 2^(ADDR_BITS-2) words (default 1024).
- `LOG_EN`, default 1: when 1, each committed store issues the `$display` trace line.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high; starts the clear sweep.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `we` in 1: store request.
- `size` in 2: 00 byte, 01 half, 10 word; 11 is reserved and treated as word.
- `load_unsigned` in 1: 1 zero-extends byte/half loads, 0 sign-extends.
- `pc` in 32: PC of the MEM-stage instruction, used only for the trace.
- `rdata` out 32: extended load data.
- `busy` out 1: clear sweep in progress.
- `misalign` out 1: half access with addr[0]=1, or word access with addr[1:0]!=0.
- `range_err` out 1: addr[31:ADDR_BITS] is nonzero.

## Operation
- Storage: DEPTH x 32-bit array, indexed by `idx = addr[ADDR_BITS-1:2]`. Simulation initial contents are all 0.
- FSM has two states, IDLE and CLEAR, held in a state register with pointer `ptr` (ADDR_BITS-2 bits).
  - Any state, reset=1 at an edge: state <= CLEAR, ptr <= 0. No array write occurs on that edge.
  - CLEAR, reset=0: mem[ptr] <= 0, ptr <= ptr+1. If ptr == DEPTH-1, state <= IDLE and ptr <= 0.
  - IDLE, reset=0: service stores.
  - Power-up (simulation initial) state is IDLE.
- `busy` = (state == CLEAR). It is combinational from the state register.
- Store commit condition: state==IDLE, reset=0, we=1, misalign=0, range_err=0. If any condition fails, the store is dropped silently; the array is unchanged and no trace line is printed.
- Byte-lane write on commit:
  - Byte: lane addr[1:0] <= wdata[7:0].
  - Half: lanes {addr[1],1'b1} and {addr[1],1'b0} <= wdata[15:0], little-endian (addr[1]=0 selects [15:0]).
  - Word: all four lanes <= wdata.
  - Unselected lanes keep their value.
- Trace, when LOG_EN=1, at the commit edge: `$display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word)`. `merged_word` is the full 32-bit word after the lane merge.
- Load path is combinational. Take w = mem[idx], then:
  - Byte: select w[8*addr[1:0] +: 8] and extend per `load_unsigned`.
  - Half: select w[16*addr[1] +: 16] and extend.
  - Word: pass w through.
- `rdata` is forced to 0 while busy=1, misalign=1 or range_err=1.
- `misalign` and `range_err` are purely combinational from addr and size, independent of `we` and `busy`. Byte accesses never raise `misalign`.

## Timing
- Load latency is zero cycles (asynchronous read). A read of the word being stored in the same cycle returns the pre-store value; the new value is visible after the edge.
- Store takes effect on the rising edge where the commit condition holds.
- Reset sequence: the first edge with reset=1 puts busy=1. The sweep then takes exactly DEPTH edges with reset=0. busy falls after the DEPTH-th such edge; with default parameters, busy=1 for 1024 cycles after reset deasserts.
- Holding reset high keeps ptr=0 and busy=1. Reasserting reset mid-sweep restarts at ptr=0, and words already cleared stay cleared.
- Output values under reset: busy=1 and rdata=0. misalign and range_err reflect the current inputs.
- A store issued while busy=1 is dropped. The pipeline must hold the MEM-stage instruction until busy=0.

## Test plan
- **Reset sweep:** pulse reset for 1 cycle with defaults. busy=1 for 1024 cycles after deassert, then 0. All words read 0, and a store during the sweep does not persist.
- **Byte stores:** sw 0x11223344 @0x10, then sb 0xAA @0x11 and sb 0xBB @0x13. Word reads 0xBB22AA44. Trace shows `*00000010 <= bb22aa44` for the last store.
- **Load extension:** mem[0x20]=0x80FF7F01. Expected results:
  - lb @0x22 gives 0xFFFFFFFF; lbu @0x23 gives 0x00000080.
  - lh @0x22 gives 0xFFFF80FF; lhu @0x20 gives 0x00007F01.
- **Misalignment:** sh @0x31 and sw @0x32 both raise misalign=1, leave memory unchanged and print no trace. sb @0x31 gives misalign=0.
- **Range and parameters:** with ADDR_BITS=8, sw @0x100 gives range_err=1 and is dropped. A sweep after reset lasts 64 cycles.
- **Reset mid-sweep and read-during-write:** reset again at sweep cycle 500; busy then lasts a further 1024 cycles. In the cycle of sw 0x5 @0x40 (old value 0), rdata @0x40 is 0, and it is 5 on the next cycle.
